// File: rtl/rx_oversample_counter.sv
// Oversampling edge/bit counter for the UART receiver: tracks the oversample index and bit index
// within a frame, and decodes the mid-bit sample window plus bit/frame completion strobes.
module rx_oversample_counter #(
  parameter int unsigned PRESCALE_W = 6,
  parameter int unsigned BIT_CNT_W  = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_enable,
  input  logic [PRESCALE_W-1:0] i_prescale,
  input  logic [3:0]            i_data_len,
  input  logic                  i_par_en,
  input  logic                  i_stop2,
  output logic [PRESCALE_W-1:0] o_edge_cnt,
  output logic [BIT_CNT_W-1:0]  o_bit_cnt,
  output logic                  o_sample_pre,
  output logic                  o_sample_mid,
  output logic                  o_sample_post,
  output logic                  o_bit_done,
  output logic                  o_frame_done,
  output logic                  o_busy,
  output logic                  o_cfg_err
);

  localparam logic [PRESCALE_W-1:0] MinPrescale = PRESCALE_W'(4);
  localparam logic [3:0]            MinDataLen  = 4'd5;
  localparam logic [3:0]            MaxDataLen  = 4'd8;

  typedef enum logic [1:0] {StIdle, StCount, StDone} state_e;

  state_e                r_state;
  state_e                w_state_next;
  logic [PRESCALE_W-1:0] r_edge_cnt;
  logic [PRESCALE_W-1:0] w_edge_cnt_next;
  logic [BIT_CNT_W-1:0]  r_bit_cnt;
  logic [BIT_CNT_W-1:0]  w_bit_cnt_next;

  logic [PRESCALE_W-1:0] r_ps;
  logic [3:0]            r_data_len;
  logic                  r_par_en;
  logic                  r_stop2;
  logic                  r_cfg_err;

  logic                  w_latch;
  logic                  w_ps_bad;
  logic                  w_len_bad;
  logic [PRESCALE_W-1:0] w_ps_clamped;
  logic [3:0]            w_len_clamped;

  logic                  w_in_count;
  logic [PRESCALE_W-1:0] w_mid;
  logic [PRESCALE_W-1:0] w_ps_last;
  logic [BIT_CNT_W-1:0]  w_frame_last;
  logic                  w_bit_done;
  logic                  w_frame_done;

  // Clamp decisions use the raw inputs so cfg_err reflects what the FSM was handed.
  always_comb begin
    w_ps_bad      = (i_prescale < MinPrescale);
    w_len_bad     = (i_data_len < MinDataLen) || (i_data_len > MaxDataLen);
    w_ps_clamped  = w_ps_bad ? MinPrescale : i_prescale;
    w_len_clamped = w_len_bad ? MaxDataLen : i_data_len;
  end

  // F-1 = start + data + parity + stop(s) - 1 = data_len + par_en + stop2 + 1
  always_comb begin
    w_in_count   = (r_state == StCount);
    w_mid        = r_ps >> 1;
    w_ps_last    = r_ps - PRESCALE_W'(1);
    w_frame_last = BIT_CNT_W'(r_data_len) + BIT_CNT_W'(r_par_en) + BIT_CNT_W'(r_stop2)
                 + BIT_CNT_W'(1);
    w_bit_done   = w_in_count && (r_edge_cnt == w_ps_last);
    w_frame_done = w_bit_done && (r_bit_cnt == w_frame_last);
  end

  always_comb begin
    w_state_next    = r_state;
    w_edge_cnt_next = r_edge_cnt;
    w_bit_cnt_next  = r_bit_cnt;
    w_latch         = 1'b0;
    if (!i_enable) begin
      w_state_next    = StIdle;
      w_edge_cnt_next = '0;
      w_bit_cnt_next  = '0;
    end else begin
      case (r_state)
        StIdle: begin
          w_latch         = 1'b1;
          w_state_next    = StCount;
          w_edge_cnt_next = '0;
          w_bit_cnt_next  = '0;
        end
        StCount: begin
          if (w_frame_done) begin
            w_state_next    = StDone;
            w_edge_cnt_next = '0;
            w_bit_cnt_next  = '0;
          end else if (w_bit_done) begin
            w_edge_cnt_next = '0;
            w_bit_cnt_next  = r_bit_cnt + BIT_CNT_W'(1);
          end else begin
            w_edge_cnt_next = r_edge_cnt + PRESCALE_W'(1);
          end
        end
        StDone: begin
          // Held here until enable drops so a frame needs a fresh rising enable.
          w_edge_cnt_next = '0;
          w_bit_cnt_next  = '0;
        end
        default: begin
          w_state_next    = StIdle;
          w_edge_cnt_next = '0;
          w_bit_cnt_next  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= StIdle;
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
    end else begin
      r_state    <= w_state_next;
      r_edge_cnt <= w_edge_cnt_next;
      r_bit_cnt  <= w_bit_cnt_next;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ps       <= MinPrescale;
      r_data_len <= MaxDataLen;
      r_par_en   <= 1'b0;
      r_stop2    <= 1'b0;
      r_cfg_err  <= 1'b0;
    end else if (w_latch) begin
      r_ps       <= w_ps_clamped;
      r_data_len <= w_len_clamped;
      r_par_en   <= i_par_en;
      r_stop2    <= i_stop2;
      r_cfg_err  <= w_ps_bad || w_len_bad;
    end
  end

  always_comb begin
    o_edge_cnt    = r_edge_cnt;
    o_bit_cnt     = r_bit_cnt;
    o_busy        = w_in_count;
    o_cfg_err     = r_cfg_err;
    o_sample_pre  = w_in_count && (r_edge_cnt == w_mid - PRESCALE_W'(1));
    o_sample_mid  = w_in_count && (r_edge_cnt == w_mid);
    o_sample_post = w_in_count && (r_edge_cnt == w_mid + PRESCALE_W'(1));
    o_bit_done    = w_bit_done;
    o_frame_done  = w_frame_done;
  end

endmodule
